// File: rtl/oled_spi_driver.sv
// rtl/oled_spi_driver.sv - SSD1331 OLED power-up, init and continuous RGB565 pixel streaming over 4-wire SPI
module oled_spi_driver #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int PWR_DELAY  = 125000,
  parameter int RST_CYCLES = 20,
  parameter int VCC_DELAY  = 156250
) (
  input  logic        clk_6p25,
  input  logic        reset_n,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam logic [12:0] LAST_PIX = 13'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, RST_LOW, RST_WAIT, INIT_CMD, VCC_WAIT, DISP_ON, PREFETCH, STREAM
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [3:0]  byte_q, byte_d;
  logic [15:0] word_q, word_d;
  logic [12:0] pixel_index_q, pixel_index_d, next_index;
  logic        frame_begin_q, frame_begin_d;
  logic        sending_pixels_q, sending_pixels_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        sdin_q, sdin_d;
  logic        d_cn_q, d_cn_d;
  logic        resn_q, resn_d;
  logic        vccen_q, vccen_d;
  logic        pmoden_q, pmoden_d;
  logic [7:0]  cmd_byte;

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0:    init_byte = 8'hAE;
      4'd1:    init_byte = 8'hA0;
      4'd2:    init_byte = 8'h72;
      4'd3:    init_byte = 8'h15;
      4'd4:    init_byte = 8'h00;
      4'd5:    init_byte = 8'h5F;
      4'd6:    init_byte = 8'h75;
      4'd7:    init_byte = 8'h00;
      default: init_byte = 8'h3F;
    endcase
  endfunction

  assign next_index = (pixel_index_q == LAST_PIX) ? 13'd0 : pixel_index_q + 13'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 18'd1;
    byte_d        = byte_q;
    word_d        = word_q;
    pixel_index_d = pixel_index_q;
    frame_begin_d = 1'b0;
    case (state_q)
      PWR_WAIT: if (cnt_q == 18'(PWR_DELAY - 1)) begin
        state_d = RST_LOW;
        cnt_d   = '0;
      end
      RST_LOW: if (cnt_q == 18'(RST_CYCLES - 1)) begin
        state_d = RST_WAIT;
        cnt_d   = '0;
      end
      RST_WAIT: if (cnt_q == 18'(RST_CYCLES - 1)) begin
        state_d = INIT_CMD;
        cnt_d   = '0;
        byte_d  = 4'd0;
      end
      INIT_CMD: if (cnt_q[3:0] == 4'd15) begin
        cnt_d = '0;
        if (byte_q == 4'd8) state_d = VCC_WAIT;
        else                byte_d  = byte_q + 4'd1;
      end
      VCC_WAIT: if (cnt_q == 18'(VCC_DELAY - 1)) begin
        state_d = DISP_ON;
        cnt_d   = '0;
      end
      DISP_ON: if (cnt_q[3:0] == 4'd15) begin
        state_d       = PREFETCH;
        cnt_d         = '0;
        pixel_index_d = 13'd0;
        frame_begin_d = 1'b1;
      end
      PREFETCH: if (cnt_q == 18'd3) begin
        state_d       = STREAM;
        cnt_d         = '0;
        word_d        = pixel_data;
        pixel_index_d = next_index;
        frame_begin_d = (next_index == 13'd0);
      end
      default: if (cnt_q[4:0] == 5'd31) begin
        // Slot boundary: latch the settled colour and move renderers to the next pixel.
        cnt_d         = '0;
        word_d        = pixel_data;
        pixel_index_d = next_index;
        frame_begin_d = (next_index == 13'd0);
      end
    endcase

    // Pin values are derived from the next state so every output comes straight from a flop.
    cmd_byte         = (state_d == DISP_ON) ? 8'hAF : init_byte(byte_d);
    sclk_d           = 1'b1;
    sdin_d           = 1'b0;
    cs_n_d           = 1'b1;
    d_cn_d           = 1'b0;
    sending_pixels_d = 1'b0;
    resn_d           = (state_d != RST_LOW);
    vccen_d          = state_d inside {VCC_WAIT, DISP_ON, PREFETCH, STREAM};
    pmoden_d         = 1'b1;
    case (state_d)
      INIT_CMD, DISP_ON: begin
        cs_n_d = 1'b0;
        sclk_d = cnt_d[0];
        sdin_d = cmd_byte[3'd7 - cnt_d[3:1]];
      end
      STREAM: begin
        cs_n_d           = 1'b0;
        d_cn_d           = 1'b1;
        sending_pixels_d = 1'b1;
        sclk_d           = cnt_d[0];
        sdin_d           = word_d[4'd15 - cnt_d[4:1]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_6p25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= PWR_WAIT;
      cnt_q            <= '0;
      byte_q           <= '0;
      word_q           <= '0;
      pixel_index_q    <= '0;
      frame_begin_q    <= 1'b0;
      sending_pixels_q <= 1'b0;
      cs_n_q           <= 1'b1;
      sclk_q           <= 1'b1;
      sdin_q           <= 1'b0;
      d_cn_q           <= 1'b0;
      resn_q           <= 1'b1;
      vccen_q          <= 1'b0;
      pmoden_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      byte_q           <= byte_d;
      word_q           <= word_d;
      pixel_index_q    <= pixel_index_d;
      frame_begin_q    <= frame_begin_d;
      sending_pixels_q <= sending_pixels_d;
      cs_n_q           <= cs_n_d;
      sclk_q           <= sclk_d;
      sdin_q           <= sdin_d;
      d_cn_q           <= d_cn_d;
      resn_q           <= resn_d;
      vccen_q          <= vccen_d;
      pmoden_q         <= pmoden_d;
    end
  end

  assign pixel_index    = pixel_index_q;
  assign frame_begin    = frame_begin_q;
  assign sending_pixels = sending_pixels_q;
  assign cs_n           = cs_n_q;
  assign sclk           = sclk_q;
  assign sdin           = sdin_q;
  assign d_cn           = d_cn_q;
  assign resn           = resn_q;
  assign vccen          = vccen_q;
  assign pmoden         = pmoden_q;

endmodule
